conv25d_seq: RTL and testbench
==============================

CONV25D_SEQ -- requirements
Module: conv25d_seq

Parameters
REQ-001 SHALL provide IMG_WIDTH, default 6, pixels per input row.
REQ-002 SHALL provide IMG_HEIGHT, default 6, rows per frame.
REQ-003 SHALL provide K_SIZE, default 4, kernel edge length.
REQ-004 SHALL provide PIPE_LAT, default 6, datapath clocks from pixel accept to window result (5 mult-adder tree + 1 Z adder).
REQ-005 SHALL provide CW = clog2(IMG_WIDTH) and RW = clog2(IMG_HEIGHT) as derived widths.

Interface
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle frame start request.
REQ-009 in_valid  input  1  upstream pixel vector present.
REQ-010 in_ready  output  1  sequencer accepts a pixel this cycle.
REQ-011 dp_advance  output  1  shift-enable to convolution datapath; combinational in_valid AND in_ready.
REQ-012 out_valid  output  1  datapath pixel_vector_out holds a valid window result this cycle.
REQ-013 out_col  output  CW  window left column of current result.
REQ-014 out_row  output  RW  window top row of current result.
REQ-015 busy  output  1  high outside IDLE.
REQ-016 frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-017 SHALL implement states IDLE, ACTIVE, DRAIN.
REQ-018 IDLE -> ACTIVE on start; start in ACTIVE/DRAIN ignored.
REQ-019 in_ready SHALL be 1 only in ACTIVE; accept = in_valid AND in_ready at a rising edge.
REQ-020 Input col counter SHALL increment per accept, wrap IMG_WIDTH-1 -> 0 and increment row; no change on cycles without accept.
REQ-021 Accept of pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1) SHALL move ACTIVE -> DRAIN and clear col/row to 0.
REQ-022 Each accept SHALL push tag = (row >= K_SIZE-1 AND col >= K_SIZE-1) with coordinates (col-(K_SIZE-1), row-(K_SIZE-1)) into a PIPE_LAT-stage free-running tag pipeline; non-accept cycles push tag 0.
REQ-023 out_valid/out_col/out_row SHALL be the pipeline output, asserted exactly PIPE_LAT clocks after the accept edge; out_col/out_row SHALL be 0 when out_valid is 0.
REQ-024 Pixels with col < K_SIZE-1 (row wrap-around windows) SHALL never produce out_valid.
REQ-025 DRAIN SHALL last PIPE_LAT clocks (down-counter), then return to IDLE with frame_done high for exactly that one cycle following the last DRAIN cycle.
REQ-026 Valid results per frame SHALL equal (IMG_WIDTH-K_SIZE+1)*(IMG_HEIGHT-K_SIZE+1).
REQ-027 Input stalls (in_valid low in ACTIVE) SHALL delay, not drop, subsequent tags; no output backpressure exists.
REQ-028 start coincident with frame_done cycle SHALL be accepted (IDLE on that cycle).

Reset
REQ-029 Reset low SHALL force IDLE, clear counters and all tag stages; in_ready, dp_advance, out_valid, busy, frame_done, out_col, out_row = 0.
REQ-030 Reset mid-frame SHALL discard in-flight tags; no out_valid until a new frame's tags emerge.

Verification (defaults)
REQ-031 start, in_valid held 1 for 36 accepts -> first out_valid 6 clocks after 22nd accept, out_col=0, out_row=0.
REQ-032 Same stream -> out_valid on accepts 22,23,24 +6 clocks (cols 0,1,2), none for accepts 25-27; 9 results total, last out_col=2, out_row=2.
REQ-033 Deassert in_valid 3 cycles after accept 10 -> all 9 results present, each exactly 6 clocks after its accept, dp_advance low during stall.
REQ-034 Last accept -> busy high 6 more clocks, frame_done single pulse, in_ready 0 throughout DRAIN, start during DRAIN ignored.
REQ-035 Reset asserted after accept 23 -> all outputs 0 immediately; after release and new start, first out_valid again 6 clocks after 22nd accept.

Source files
------------

// File: rtl/conv25d_seq_if.sv
// Handshake and result bundle between the frame sequencer and its upstream/downstream peers.
interface conv25d_seq_if #(
    parameter int unsigned CW = 3,
    parameter int unsigned RW = 3
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          dp_advance;
    logic          out_valid;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;
    logic          busy;
    logic          frame_done;

    modport master (
        output start, in_valid,
        input  in_ready, dp_advance, out_valid, out_col, out_row, busy, frame_done
    );

    modport slave (
        input  start, in_valid,
        output in_ready, dp_advance, out_valid, out_col, out_row, busy, frame_done
    );
endinterface

// File: rtl/conv25d_seq.sv
// Frame sequencer for a 2.5D convolution datapath: walks the input raster, tags pixels that
// complete a full KxK window and delays the tag to line up with the datapath result.
module conv25d_seq #(
    parameter int unsigned IMG_WIDTH  = 6,
    parameter int unsigned IMG_HEIGHT = 6,
    parameter int unsigned K_SIZE     = 4,
    parameter int unsigned PIPE_LAT   = 6,
    localparam int unsigned CW        = $clog2(IMG_WIDTH),
    localparam int unsigned RW        = $clog2(IMG_HEIGHT)
) (
    input logic         clock,
    input logic         reset,
    conv25d_seq_if.slave bus
);
    localparam int unsigned DW = $clog2(PIPE_LAT + 1);
    localparam logic [CW-1:0] ColLast = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] ColOff  = CW'(K_SIZE - 1);
    localparam logic [RW-1:0] RowOff  = RW'(K_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          done_q, done_d;

    logic          tag_v_q [PIPE_LAT];
    logic [CW-1:0] tag_c_q [PIPE_LAT];
    logic [RW-1:0] tag_r_q [PIPE_LAT];

    logic          accept;
    logic          push_v;
    logic [CW-1:0] push_c;
    logic [RW-1:0] push_r;

    assign accept = bus.in_valid && (state_q == StActive);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StActive;
            end
            StActive: begin
                if (accept) begin
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            row_d   = '0;
                            state_d = StDrain;
                            drain_d = DW'(PIPE_LAT - 1);
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Columns left of K_SIZE-1 would form windows that wrap across a row boundary.
    assign push_v = accept && (col_q >= ColOff) && (row_q >= RowOff);
    assign push_c = push_v ? (col_q - ColOff) : '0;
    assign push_r = push_v ? (row_q - RowOff) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    // Free-running so a stalled input only inserts bubbles rather than freezing results.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_v_q[i] <= 1'b0;
                tag_c_q[i] <= '0;
                tag_r_q[i] <= '0;
            end
        end else begin
            tag_v_q[0] <= push_v;
            tag_c_q[0] <= push_c;
            tag_r_q[0] <= push_r;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_c_q[i] <= tag_c_q[i-1];
                tag_r_q[i] <= tag_r_q[i-1];
            end
        end
    end

    assign bus.in_ready   = (state_q == StActive);
    assign bus.dp_advance = accept;
    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_done = done_q;
    assign bus.out_valid  = tag_v_q[PIPE_LAT-1];
    assign bus.out_col    = tag_v_q[PIPE_LAT-1] ? tag_c_q[PIPE_LAT-1] : '0;
    assign bus.out_row    = tag_v_q[PIPE_LAT-1] ? tag_r_q[PIPE_LAT-1] : '0;
endmodule

// File: tb/tb_conv25d_seq.sv
// Directed bench for conv25d_seq: full frames, input stall, drain/frame_done, restart, reset.
module tb_conv25d_seq;
    localparam int unsigned W = 6, H = 6, K = 4, LAT = 6, CW = 3, RW = 3;
    localparam int NPIX = 36;
    localparam int HMAX = 1024;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    conv25d_seq_if #(.CW(CW), .RW(RW)) bus();

    conv25d_seq #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .K_SIZE(K), .PIPE_LAT(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int   idx;
        logic v;
        int   col;
        int   row;
    } vec_t;
    vec_t tbl[14];

    int   cyc = 0;
    logic hv [HMAX];
    int   hc [HMAX];
    int   hr [HMAX];
    int   acc_edge [NPIX+1];
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Entry [e] holds the registered outputs as seen by rising edge number e.
    always @(negedge clock) begin
        if (cyc + 1 < HMAX) begin
            hv[cyc+1] <= bus.out_valid;
            hc[cyc+1] <= int'(bus.out_col);
            hr[cyc+1] <= int'(bus.out_row);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_frame(input bit do_start, input int stall_after, input int stall_len,
                             input int stop_after);
        if (do_start) begin
            bus.start = 1'b1;
            @(negedge clock);
            bus.start = 1'b0;
        end
        for (int k = 1; k <= stop_after; k++) begin
            bus.in_valid = 1'b1;
            #1;
            check("in_ready_active", bus.in_ready, 1);
            check("dp_advance_accept", bus.dp_advance, 1);
            acc_edge[k] = cyc + 1;
            @(negedge clock);
            if (k == stall_after) begin
                repeat (stall_len) begin
                    bus.in_valid = 1'b0;
                    #1;
                    check("dp_advance_stall", bus.dp_advance, 0);
                    @(negedge clock);
                end
            end
        end
        if (stop_after == NPIX) bus.in_valid = 1'b0;
    endtask

    task automatic check_results(input string tag);
        int n;
        int e;
        foreach (tbl[i]) begin
            e = acc_edge[tbl[i].idx] + LAT;
            check({tag, "_out_valid"}, hv[e], tbl[i].v);
            check({tag, "_out_col"}, hc[e], tbl[i].col);
            check({tag, "_out_row"}, hr[e], tbl[i].row);
        end
        n = 0;
        for (int j = acc_edge[1]; j <= acc_edge[NPIX] + LAT; j++) n += int'(hv[j]);
        check({tag, "_result_count"}, n, (W - K + 1) * (H - K + 1));
    endtask

    // Entered on the falling edge right after the last accept edge.
    task automatic drain_check(input bit restart);
        for (int j = 1; j <= LAT; j++) begin
            bus.start = (j == 3);
            #1;
            check("drain_busy", bus.busy, 1);
            check("drain_in_ready", bus.in_ready, 0);
            check("drain_no_done", bus.frame_done, 0);
            @(negedge clock);
        end
        bus.start = 1'b0;
        #1;
        check("frame_done_pulse", bus.frame_done, 1);
        check("idle_busy", bus.busy, 0);
        if (!restart) begin
            @(negedge clock);
            #1;
            check("frame_done_single", bus.frame_done, 0);
            check("start_in_drain_ignored", bus.busy, 0);
        end
    endtask

    initial begin
        int nv;
        tbl[0]  = '{22, 1'b1, 0, 0};
        tbl[1]  = '{23, 1'b1, 1, 0};
        tbl[2]  = '{24, 1'b1, 2, 0};
        tbl[3]  = '{25, 1'b0, 0, 0};
        tbl[4]  = '{26, 1'b0, 0, 0};
        tbl[5]  = '{27, 1'b0, 0, 0};
        tbl[6]  = '{28, 1'b1, 0, 1};
        tbl[7]  = '{29, 1'b1, 1, 1};
        tbl[8]  = '{30, 1'b1, 2, 1};
        tbl[9]  = '{34, 1'b1, 0, 2};
        tbl[10] = '{35, 1'b1, 1, 2};
        tbl[11] = '{36, 1'b1, 2, 2};
        tbl[12] = '{1,  1'b0, 0, 0};
        tbl[13] = '{21, 1'b0, 0, 0};

        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_dp_advance", bus.dp_advance, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_out_col", bus.out_col, 0);
        check("rst_out_row", bus.out_row, 0);
        bus.in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("idle_ignores_no_start", bus.in_ready, 0);
        @(negedge clock);

        // Unstalled frame.
        run_frame(1'b1, 0, 0, NPIX);
        drain_check(1'b0);
        check_results("f1");

        // Stall after accept 10, then restart on the frame_done cycle.
        @(negedge clock);
        run_frame(1'b1, 10, 3, NPIX);
        drain_check(1'b1);
        check_results("f2");
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        #1;
        check("restart_busy", bus.busy, 1);
        check("restart_in_ready", bus.in_ready, 1);

        // Reset mid-frame after accept 23.
        run_frame(1'b0, 0, 0, 23);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_frame_done", bus.frame_done, 0);
        check("mid_rst_out_col", bus.out_col, 0);
        check("mid_rst_out_row", bus.out_row, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        nv = 0;
        repeat (10) begin
            @(negedge clock);
            #1;
            nv += int'(bus.out_valid) + int'(bus.busy);
        end
        check("post_rst_quiet", nv, 0);

        run_frame(1'b1, 0, 0, NPIX);
        drain_check(1'b0);
        check_results("f3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
